// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver for two BCD countdown pairs.
// Optional blink of near-expired pairs (00-03) is enabled by defining BLINK_EN.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned BLINK_DIV = 8
) (
    input  logic       CLK,
    input  logic       R,
    input  logic [3:0] nOut11,
    input  logic [3:0] nOut12,
    input  logic [3:0] nOut21,
    input  logic [3:0] nOut22,
    output logic [6:0] SEG,
    output logic [3:0] AN,
    output logic       FRAME
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("seg_scan_driver: SCAN_DIV must be at least 2");
    end
    if (BLINK_DIV < 1) begin : g_bad_blink_div
        $error("seg_scan_driver: BLINK_DIV must be at least 1");
    end

    typedef enum logic {
        S_LOAD,
        S_SCAN
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;
    logic              frame_q, frame_d;
    logic [3:0]        digit_c;
    logic [6:0]        digit_seg_c;
    logic              blink_blank_c;

`ifdef BLINK_EN
    localparam int unsigned BLK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [BLK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    logic [3:0]        pair_tens_c, pair_units_c;
`endif

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    // Segment pattern for the digit currently selected by idx, from snapshots only
    always_comb begin
        digit_c = snap_q[idx_q];
`ifdef BLINK_EN
        pair_tens_c   = snap_q[{idx_q[1], 1'b0}];
        pair_units_c  = snap_q[{idx_q[1], 1'b1}];
        blink_blank_c = blink_phase_q && (pair_tens_c == 4'd0) && (pair_units_c <= 4'd3);
`else
        blink_blank_c = 1'b0;
`endif
        if (blink_blank_c) begin
            digit_seg_c = SEG_BLANK;
        end else if (!idx_q[0] && (digit_c == 4'd0)) begin
            digit_seg_c = SEG_BLANK;
        end else begin
            digit_seg_c = bcd_to_seg(digit_c);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        seg_d   = seg_q;
        an_d    = an_q;
        frame_d = 1'b0;
`ifdef BLINK_EN
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
`endif
        case (state_q)
            S_LOAD: begin
                snap_d  = {nOut22, nOut21, nOut12, nOut11};
                frame_d = 1'b1;
                idx_d   = 2'd0;
                cnt_d   = '0;
                state_d = S_SCAN;
            end
            S_SCAN: begin
                an_d  = 4'(4'b0001 << idx_q);
                seg_d = digit_seg_c;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        snap_d  = {nOut22, nOut21, nOut12, nOut11};
                        frame_d = 1'b1;
`ifdef BLINK_EN
                        if (blink_cnt_q == BLK_LAST) begin
                            blink_cnt_d   = '0;
                            blink_phase_d = ~blink_phase_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + BLK_W'(1);
                        end
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

`ifdef BLINK_EN
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`endif

    assign SEG   = seg_q;
    assign AN    = an_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle-count reference model predicts
// FRAME/AN/SEG after every edge; a negedge monitor pops and compares.
module tb_seg_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;
    localparam int FL        = 4 * SCAN_DIV;

    typedef struct packed {
        logic       frame;
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic       CLK = 1'b0;
    logic       R;
    logic [3:0] n11, n12, n21, n22;
    logic [6:0] SEG;
    logic [3:0] AN;
    logic       FRAME;

    int   errors = 0;
    int   checks = 0;
    int   e = 0;
    exp_t exp_q[$];

    logic [3:0][3:0] snap;
    exp_t            mx;
    int              slot, didx, fnum;

    seg_scan_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
        .CLK(CLK), .R(R),
        .nOut11(n11), .nOut12(n12), .nOut21(n21), .nOut22(n22),
        .SEG(SEG), .AN(AN), .FRAME(FRAME)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] ref_seg(input int idx, input logic [3:0][3:0] s, input int f);
        logic [3:0] code;
        int pb;
        pb = (idx / 2) * 2;
        code = s[idx];
`ifdef BLINK_EN
        if (((f / BLINK_DIV) % 2) == 1 && s[pb] == 4'd0 && s[pb + 1] <= 4'd3) return 7'b0000000;
`else
        if (f < 0 || pb < 0) return 7'b0000000;
`endif
        if (code > 4'd9) return 7'b0000001;
        if ((idx % 2) == 0 && code == 4'd0) return 7'b0000000;
        case (code)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got frame=%b an=%b seg=%b, expected frame=%b an=%b seg=%b",
                     name, $time, got.frame, got.an, got.seg, want.frame, want.an, want.seg);
        end
    endtask

    // Reference model: edge 1 after reset is the load; snapshots every FL edges after it
    always @(posedge CLK) begin
        if (R) begin
            e = 0;
            exp_q.delete();
        end else begin
            e++;
            mx = '0;
            if (e >= 2) begin
                slot   = (e - 2) % FL;
                didx   = slot / SCAN_DIV;
                fnum   = (e - 2) / FL;
                mx.an  = 4'(1 << didx);
                mx.seg = ref_seg(didx, snap, fnum);
            end
            if ((e - 1) % FL == 0) begin
                snap     = {n22, n21, n12, n11};
                mx.frame = 1'b1;
            end
            exp_q.push_back(mx);
        end
    end

    // Monitor
    always @(negedge CLK) begin
        if (R) begin
            check("reset_hold", {FRAME, AN, SEG}, '0);
        end else if (exp_q.size() > 0) begin
            check("scan", {FRAME, AN, SEG}, exp_q.pop_front());
        end else begin
            check("idle", {FRAME, AN, SEG}, '0);
        end
    end

    task automatic set_in(input logic [3:0] a1, input logic [3:0] a2,
                          input logic [3:0] b1, input logic [3:0] b2);
        n11 = a1; n12 = a2; n21 = b1; n22 = b2;
    endtask

    task automatic wait_phase(input int ph);
        int guard;
        guard = 0;
        @(negedge CLK);
        while ((e % FL) != ph && guard < 4 * FL) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 4 * FL) begin
            errors++;
            checks++;
            $display("FAIL wait_phase: phase %0d not reached, e=%0d", ph, e);
        end
    endtask

    task automatic rand_run(input int cycles);
        logic [3:0] v;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if ($urandom_range(0, 5) == 0) begin
                v = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                case ($urandom_range(0, 3))
                    0: n11 = v;
                    1: n12 = v;
                    2: n21 = v;
                    default: n22 = v;
                endcase
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b1;
        set_in(4'd1, 4'd5, 4'd0, 4'd9);
        repeat (3) @(negedge CLK);
        R = 1'b0;
        repeat (2 * FL + 2) @(negedge CLK);

        // Change inputs mid-frame while digit 1 is shown
        wait_phase(7);
        set_in(4'd1, 4'd4, 4'd0, 4'd8);
        repeat (2 * FL) @(negedge CLK);

        // Out-of-range codes show a dash, including in a tens position
        set_in(4'd2, 4'd7, 4'hF, 4'hC);
        repeat (2 * FL) @(negedge CLK);

        // Near-expired pair next to a normal pair
        set_in(4'd0, 4'd3, 4'd2, 4'd5);
        repeat (2 * FL) @(negedge CLK);

        rand_run(600);

        // Asynchronous reset while digit 2 is shown
        set_in(4'd1, 4'd5, 4'd3, 4'd9);
        repeat (FL) @(negedge CLK);
        wait_phase(11);
        check("pre_reset_an", {1'b0, AN, 7'b0}, {1'b0, 4'b0100, 7'b0});
        #2 R = 1'b1;
        #1 check("async_reset", {FRAME, AN, SEG}, '0);
        repeat (3) @(negedge CLK);
        R = 1'b0;
        repeat (2 * FL + 3) @(negedge CLK);

        rand_run(300);
        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset.
REQ-002 Parameter SCAN_DIV, default 4: the number of CLK cycles each digit is displayed (minimum 2).
REQ-003 Parameter BLINK_DIV, default 8: the number of scan frames per blink half-period (used only with BLINK_EN).
REQ-004 Port CLK, input, 1 bit: system clock; all state changes on its rising edge.
REQ-005 Port R, input, 1 bit: asynchronous active-high reset.
REQ-006 Port nOut11, input, 4 bits: BCD tens digit of the direction-A countdown.
REQ-007 Port nOut12, input, 4 bits: BCD units digit of the direction-A countdown.
REQ-008 Port nOut21, input, 4 bits: BCD tens digit of the direction-B countdown.
REQ-009 Port nOut22, input, 4 bits: BCD units digit of the direction-B countdown.
REQ-010 Port SEG, output, 7 bits: active-high segments, with bit6=a, bit5=b, and so on down to bit0=g.
REQ-011 Port AN, output, 4 bits: one-hot active-high digit enable, with bit0=nOut11 and bit3=nOut22.
REQ-012 Port FRAME, output, 1 bit: one-cycle pulse when a new input snapshot is taken.

Function
REQ-013 The FSM SHALL have two states: LOAD and SCAN.
- LOAD lasts exactly one cycle.
- In LOAD, the block captures all four inputs into snapshot registers, pulses FRAME, sets idx=0 and cnt=0, then enters SCAN.
REQ-014 In SCAN, cnt SHALL increment every cycle.
- When cnt==SCAN_DIV-1: cnt wraps to 0 and idx advances 0->1->2->3->0.
REQ-015 On the cycle where idx wraps 3->0, the block SHALL re-capture all four snapshots and pulse FRAME for exactly one cycle.
- Frame period is 4*SCAN_DIV cycles.
REQ-016 Digits SHALL be displayed only from snapshot registers.
- Input changes mid-frame are invisible until the next snapshot.
REQ-017 SEG and AN SHALL be registered.
- They reflect idx with exactly one cycle of latency.
- Each AN value is held for exactly SCAN_DIV cycles.
REQ-018 Segment encoding SHALL be:
- 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
- 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
REQ-019 A snapshot code greater than 9 SHALL display a dash, SEG=0000001.
REQ-020 A tens digit (idx 0 or 2) equal to 0 SHALL be blanked.
- SEG=0000000 while AN is still asserted.
- Units digits are never blanked by this rule.
REQ-021 AN SHALL always be exactly one-hot while in SCAN; no overlap or gap cycles occur between digits.

Reset
REQ-022 While R=1, the block SHALL hold the following values, applied asynchronously:
- state=LOAD, cnt=0, idx=0, snapshots=0, blink phase=0 and blink counter=0
- SEG=0000000, AN=0000, FRAME=0
REQ-023 After R deasserts, the first clock edge SHALL execute LOAD.
- The first non-zero AN (0001) appears one cycle later.
REQ-024 Assertion of R mid-scan SHALL abort the frame immediately; no partial digit completes.

Configuration
REQ-025 The macro BLINK_EN SHALL control the blink feature; when defined:
- A frame counter toggles a blink phase every BLINK_DIV frames, counted at snapshot events.
- While phase=1, a pair whose snapshot value is 00-03 (tens==0, units<=3) SHALL output SEG=0000000 for both of its digits.
- AN is unaffected.
REQ-026 When BLINK_EN is undefined, the blink counter and phase SHALL not exist and no digit is ever forced blank by blinking.

Verification
REQ-027 SCAN_DIV=4, inputs 1,5,0,9 -> the following sequence, repeating every 16 cycles:
- AN=0001 with SEG=0110000 for 4 cycles
- AN=0010 with SEG=1011011 for 4 cycles
- AN=0100 with SEG=0000000 (leading-zero blank) for 4 cycles
- AN=1000 with SEG=1111011 for 4 cycles
REQ-028 nOut22=4'hC -> digit 3 shows SEG=0000001; nOut21=4'hF -> digit 2 shows the dash, not a blank.
REQ-029 Inputs change from 15/09 to 14/08 while idx=1 -> displayed values stay 1,5,0,9 until FRAME pulses; the following frame shows 1,4,0,8.
REQ-030 R asserted while AN=0100 -> AN=0000 and SEG=0000000 without waiting for a clock edge; after release, LOAD on edge 1 and AN=0001 on edge 2.
REQ-031 BLINK_EN defined, BLINK_DIV=2, A=03, B=25 -> digits 0-1 show normally for frames 0-1 and SEG=0000000 for frames 2-3, alternating thereafter; digits 2-3 are never blanked.
REQ-032 BLINK_EN undefined, A=03 -> digits 0-1 display 0000000 (tens blank) and 1111001 in every frame.
